// File: rtl/shr_pkg.sv
// Shared definitions for the sequential right shifter (shr_seq).
//   SHR_WIDTH   : default operand/result width
//   CNT_W       : shift counter width for the default width (holds 0..SHR_WIDTH)
//   shr_state_t : FSM state encoding
package shr_pkg;

    localparam int unsigned SHR_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(SHR_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_t;

endpackage

// File: rtl/shr_flag_gen.sv
// Flag generator for shr_seq. Purely combinational; it works on the value that
// is about to be registered into O0, so the flags land in the same cycle as the
// result.
// Ports:
//   data_next : result value about to be registered
//   zero      : data_next == 0
//   sign      : data_next[WIDTH-1]
//   o4, o5    : unused PE flag slots, tied low
module shr_flag_gen #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_next,
    output logic             zero,
    output logic             sign,
    output logic             o4,
    output logic             o5
);

    assign zero = (data_next == '0);
    assign sign = data_next[WIDTH-1];
    assign o4   = 1'b0;
    assign o5   = 1'b0;

endmodule

// File: rtl/shr_seq.sv
// Sequential right shifter, one bit per cycle, with valid/ready handshakes on
// both sides and the standard five PE flag outputs.
// Optional feature macro: SHR_ARITH_EN adds the signed_op port and
// sign-extending (arithmetic) shifts; without it every shift is logical.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : value to shift, unsigned shift amount (clamped to WIDTH)
//   signed_op           : arithmetic shift select (SHR_ARITH_EN only)
//   out_valid/out_ready : result handshake
//   O0                  : shifted result
//   O1                  : carry, last bit shifted out (0 for a zero shift)
//   O2, O3              : zero and sign flags of O0
//   O4, O5              : constant 0
module shr_seq
    import shr_pkg::*;
#(
    parameter int unsigned WIDTH = SHR_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SHR_ARITH_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O0,
    output logic             O1,
    output logic             O2,
    output logic             O3,
    output logic             O4,
    output logic             O5
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]  W_WIDE = (WIDTH + 1)'(WIDTH);
    localparam logic [CW-1:0]   W_CNT  = CW'(WIDTH);
    localparam logic [CW-1:0]   ONE    = CW'(1);

    shr_state_t       state;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fill;

    logic [CW-1:0]    cnt_eff;
    logic             fill_in;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             load_out;
    logic             zero_next;
    logic             sign_next;

    // Amounts of WIDTH or more all behave like a full-width shift.
    assign cnt_eff = ({1'b0, b} >= W_WIDE) ? W_CNT : b[CW-1:0];

`ifdef SHR_ARITH_EN
    assign fill_in = signed_op & a[WIDTH-1];
`else
    assign fill_in = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    // Value that enters DONE: the raw operand for a zero shift, otherwise the
    // final shift step.
    always_comb begin
        res_next   = {fill, data[WIDTH-1:1]};
        carry_next = data[0];
        if (state == IDLE) begin
            res_next   = a;
            carry_next = 1'b0;
        end
    end

    assign load_out = ((state == IDLE) && in_valid && (cnt_eff == '0)) ||
                      ((state == SHIFT) && (cnt == ONE));

    shr_flag_gen #(
        .WIDTH(WIDTH)
    ) u_flag_gen (
        .data_next(res_next),
        .zero     (zero_next),
        .sign     (sign_next),
        .o4       (O4),
        .o5       (O5)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            data      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            fill      <= 1'b0;
            out_valid <= 1'b0;
            O0        <= '0;
            O1        <= 1'b0;
            O2        <= 1'b0;
            O3        <= 1'b0;
        end else begin
            // Result registers only move on entry to DONE, so they hold
            // through backpressure and while idle/shifting.
            if (load_out) begin
                O0 <= res_next;
                O1 <= carry_next;
                O2 <= zero_next;
                O3 <= sign_next;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= a;
                        cnt   <= cnt_eff;
                        carry <= 1'b0;
                        fill  <= fill_in;
                        if (cnt_eff == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data  <= {fill, data[WIDTH-1:1]};
                    carry <= data[0];
                    cnt   <= cnt - ONE;
                    if (cnt == ONE) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
